// File: rtl/uart_tx_scheduler_if.sv
// Bundle of every signal between the transmit scheduler and its surroundings:
// the two byte requesters, the baud configuration port, the transmitter
// interface and the status outputs. The scheduler uses the slave view; the
// master view belongs to the system side (requesters plus transmitter).
interface uart_tx_scheduler_if;
    // requester 0
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    // requester 1
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    // baud configuration
    logic       cfg_wr;
    logic [2:0] cfg_baud;
    // transmitter side
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       Tx_BUSY;
    // status
    logic       grant_id;
    logic       timeout_err;

    modport master (
        output req0, data0, req1, data1, cfg_wr, cfg_baud, Tx_BUSY,
        input  ack0, ack1, baud_select, Tx_EN, Tx_WR, Tx_DATA, grant_id, timeout_err
    );

    modport slave (
        input  req0, data0, req1, data1, cfg_wr, cfg_baud, Tx_BUSY,
        output ack0, ack1, baud_select, Tx_EN, Tx_WR, Tx_DATA, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between two byte
// requesters. A granted byte is latched into Tx_DATA, announced with a
// one-cycle Tx_WR (acked to its requester in the same cycle) and the frame is
// tracked through Tx_BUSY. The scheduler also owns baud_select, which is only
// rewritten from IDLE so the baud never changes while a frame is on the line.
// Every output is a register.
module uart_tx_scheduler #(
    parameter int unsigned RISE_TIMEOUT = 16,   // WAIT_BUSY cycles allowed for Tx_BUSY to rise (>= 2)
    parameter logic [2:0]  BAUD_RESET   = 3'd0
) (
    input logic                clk,
    input logic                reset,           // asynchronous, active low
    uart_tx_scheduler_if.slave bus
);

    localparam int unsigned          TIMER_W    = $clog2(RISE_TIMEOUT);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(RISE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               tx_wr_q, tx_wr_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_en_q, tx_en_d;
    logic               grant_q, grant_d;
    logic [2:0]         baud_q, baud_d;
    logic               pend_q, pend_d;
    logic [2:0]         pend_val_q, pend_val_d;
    logic               terr_q, terr_d;
    logic               winner;

    // State register and every registered output.
    // NOTE: asynchronous active-low reset with non-blocking assignments only, so
    // all registers update together at the edge and reset acts between edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            tx_wr_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_en_q    <= 1'b0;
            grant_q    <= 1'b1;      // requester 0 wins the first tie
            baud_q     <= BAUD_RESET;
            pend_q     <= 1'b0;
            pend_val_q <= BAUD_RESET;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            tx_wr_q    <= tx_wr_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            tx_data_q  <= tx_data_d;
            tx_en_q    <= tx_en_d;
            grant_q    <= grant_d;
            baud_q     <= baud_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            terr_q     <= terr_d;
        end
    end

    // Next state, arbitration and next values of the registered outputs.
    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        timer_d    = timer_q;
        tx_wr_d    = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        baud_d     = baud_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        terr_d     = terr_q;
        winner     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // Reconfigure only between frames; Tx_EN drops for this one cycle.
                    state_d = CFG;
                    baud_d  = pend_val_q;
                    pend_d  = 1'b0;
                end else if (!bus.Tx_BUSY && (bus.req0 || bus.req1)) begin
                    // On a tie the requester that did not own the last frame wins.
                    winner    = (bus.req0 && bus.req1) ? ~grant_q : bus.req1;
                    state_d   = ISSUE;
                    tx_data_d = winner ? bus.data1 : bus.data0;
                    grant_d   = winner;
                    tx_wr_d   = 1'b1;
                    ack0_d    = ~winner;
                    ack1_d    = winner;
                end
            end
            CFG: begin
                state_d = IDLE;
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                timer_d = '0;
            end
            WAIT_BUSY: begin
                if (bus.Tx_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    // Transmitter never acknowledged the write: flag it and move
                    // on; the byte is not retried.
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            WAIT_DONE: begin
                // Frame length depends on the baud rate, so there is no timeout here.
                if (!bus.Tx_BUSY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A configuration strobe is captured in any state; the latest one wins,
        // including one arriving on the same edge that applies an older value.
        if (bus.cfg_wr) begin
            pend_d     = 1'b1;
            pend_val_d = bus.cfg_baud;
        end

        tx_en_d = (state_d != CFG);
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.Tx_WR       = tx_wr_q;
    assign bus.Tx_DATA     = tx_data_q;
    assign bus.Tx_EN       = tx_en_q;
    assign bus.baud_select = baud_q;
    assign bus.grant_id    = grant_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler. Requesters push each byte they raise into a
// per-requester expectation queue; a monitor pops and compares whenever Tx_WR
// or an ack appears, deciding the winner from the round-robin rule and the
// requests that were pending. A second model tracks baud configuration
// strobes. A simple transmitter model raises Tx_BUSY two cycles after Tx_WR.
module tb_uart_tx_scheduler;

    localparam int unsigned RISE_TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;

    uart_tx_scheduler_if bus();

    uart_tx_scheduler #(
        .RISE_TIMEOUT (RISE_TIMEOUT),
        .BAUD_RESET   (3'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // stimulus drivers
    logic       req_drv  [2];
    logic [7:0] data_drv [2];
    logic       model_busy = 1'b0;
    logic       busy_force = 1'b0;
    logic       stuck      = 1'b0;
    logic       rand_busy  = 1'b0;

    assign bus.req0    = req_drv[0];
    assign bus.data0   = data_drv[0];
    assign bus.req1    = req_drv[1];
    assign bus.data1   = data_drv[1];
    assign bus.Tx_BUSY = model_busy | busy_force;

    // scoreboard state
    logic [7:0] stim_q [2][$];
    logic [7:0] exp_q  [2][$];
    logic [7:0] log_q  [$];
    logic       grant_log [$];
    int         assert_cnt  = 0;
    int         fail_cnt    = 0;
    int         txwr_count  = 0;
    int         cfg_count   = 0;
    time        last_txwr_time = 0;
    time        last_cfg_time  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack0"},        bus.ack0,        0);
        check({tag, "_ack1"},        bus.ack1,        0);
        check({tag, "_tx_wr"},       bus.Tx_WR,       0);
        check({tag, "_tx_data"},     bus.Tx_DATA,     0);
        check({tag, "_tx_en"},       bus.Tx_EN,       0);
        check({tag, "_baud"},        bus.baud_select, 0);
        check({tag, "_grant_id"},    bus.grant_id,    1);
        check({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    task automatic pulse_cfg(input logic [2:0] v);
        @(posedge clk); #1;
        bus.cfg_wr   = 1'b1;
        bus.cfg_baud = v;
        @(posedge clk); #1;
        bus.cfg_wr   = 1'b0;
    endtask

    // Wait until nothing is queued, pending or on the line for a while.
    task automatic drain();
        int quiet = 0;
        int n     = 0;
        while (quiet < 24 && n < 5000) begin
            @(negedge clk);
            n++;
            if (stim_q[0].size() == 0 && stim_q[1].size() == 0 &&
                exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                !req_drv[0] && !req_drv[1] && !bus.Tx_BUSY && !bus.Tx_WR)
                quiet++;
            else
                quiet = 0;
        end
        check("drain_done", (quiet >= 24), 1);
    endtask

    task automatic wait_txwr();
        int n = 0;
        while (!bus.Tx_WR && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("tx_wr_seen", bus.Tx_WR, 1);
    endtask

    task automatic wait_model_busy();
        int n = 0;
        while (!model_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", model_busy, 1);
    endtask

    // Requesters: raise req with the next queued byte, hold until ack, then
    // either present the next byte or drop req.
    initial begin
        logic acked [2];
        int   waited [2];
        req_drv[0] = 1'b0; req_drv[1] = 1'b0;
        data_drv[0] = 8'h00; data_drv[1] = 8'h00;
        acked[0] = 1'b0; acked[1] = 1'b0;
        waited[0] = 0; waited[1] = 0;
        forever begin
            @(negedge clk);
            if (bus.ack0) acked[0] = 1'b1;
            if (bus.ack1) acked[1] = 1'b1;
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (req_drv[k] && !acked[k]) begin
                    waited[k]++;
                    if (waited[k] > 3000) begin
                        assert_cnt++;
                        fail_cnt++;
                        $display("FAIL ack_wait%0d: no ack after %0d cycles, expected an ack", k, waited[k]);
                        exp_q[k].delete();
                        req_drv[k] = 1'b0;
                    end
                end else begin
                    acked[k]  = 1'b0;
                    waited[k] = 0;
                    if (stim_q[k].size() > 0) begin
                        data_drv[k] = stim_q[k].pop_front();
                        exp_q[k].push_back(data_drv[k]);
                        req_drv[k] = 1'b1;
                    end else begin
                        req_drv[k] = 1'b0;
                    end
                end
            end
        end
    end

    // Transmitter model: Tx_BUSY rises two cycles after Tx_WR for a frame.
    initial begin
        int len;
        forever begin
            @(negedge clk);
            if (reset && bus.Tx_WR && !stuck) begin
                len = rand_busy ? int'($urandom_range(3, 20)) : 20;
                repeat (2) @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // Monitor: round-robin reference model plus baud configuration model.
    initial begin
        logic       last_grant_m  = 1'b1;
        logic       pend_m        = 1'b0;
        logic [2:0] pend_val_m    = 3'd0;
        logic       prev_cfg_wr   = 1'b0;
        logic [2:0] prev_cfg_baud = 3'd0;
        logic       prev_en       = 1'b1;
        logic [2:0] prev_baud     = 3'd0;
        logic [1:0] snap_req      = 2'b00;
        int         w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_grant_m = 1'b1;
                pend_m       = 1'b0;
            end else begin
                if (bus.Tx_WR || bus.ack0 || bus.ack1) begin
                    check("grant_has_req", (snap_req != 2'b00), 1);
                    if (snap_req != 2'b00) begin
                        if (snap_req == 2'b11) w = last_grant_m ? 0 : 1;
                        else                   w = snap_req[1] ? 1 : 0;
                        check("tx_wr",      bus.Tx_WR, 1);
                        check("ack_winner", (w == 1) ? bus.ack1 : bus.ack0, 1);
                        check("ack_other",  (w == 1) ? bus.ack0 : bus.ack1, 0);
                        check("grant_id",   bus.grant_id, w);
                        check("byte_queued", (exp_q[w].size() != 0), 1);
                        if (exp_q[w].size() != 0)
                            check("tx_data", bus.Tx_DATA, exp_q[w].pop_front());
                        last_grant_m = (w == 1);
                    end
                    log_q.push_back(bus.Tx_DATA);
                    grant_log.push_back(bus.grant_id);
                    txwr_count++;
                    last_txwr_time = $time;
                end
                if (!bus.Tx_EN) begin
                    check("cfg_pending",      pend_m, 1);
                    check("cfg_baud",         bus.baud_select, pend_val_m);
                    check("cfg_line_idle",    model_busy, 0);
                    check("cfg_single_cycle", prev_en, 1);
                    pend_m = 1'b0;
                    cfg_count++;
                    last_cfg_time = $time;
                end else if (bus.baud_select != prev_baud) begin
                    check("baud_stable", bus.baud_select, prev_baud);
                end
                // Strobe sampled at the edge just past joins the pending value.
                if (prev_cfg_wr) begin
                    pend_m     = 1'b1;
                    pend_val_m = prev_cfg_baud;
                end
            end
            prev_cfg_wr   = reset && bus.cfg_wr;
            prev_cfg_baud = bus.cfg_baud;
            prev_en       = reset ? bus.Tx_EN : 1'b1;
            prev_baud     = bus.baud_select;
            snap_req      = {req_drv[1], req_drv[0]};
        end
    end

    // Directed and random sequences.
    initial begin
        int          n;
        int          base;
        int          k;
        logic [31:0] r;
        reset        = 1'b0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_baud = 3'd0;

        // reset state, then Tx_EN rises on the first edge after release
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        #1 reset = 1'b1;
        @(negedge clk);
        check("tx_en_after_release", bus.Tx_EN, 1);

        // both requesters held for three frames: 11, 22, 11
        log_q.delete(); grant_log.delete();
        stim_q[0].push_back(8'h11); stim_q[0].push_back(8'h11);
        stim_q[1].push_back(8'h22);
        drain();
        check("rr_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("rr_byte0", log_q[0], 8'h11);
            check("rr_byte1", log_q[1], 8'h22);
            check("rr_byte2", log_q[2], 8'h11);
            check("rr_grant0", grant_log[0], 0);
            check("rr_grant1", grant_log[1], 1);
            check("rr_grant2", grant_log[2], 0);
        end

        // single request
        log_q.delete();
        @(negedge clk);
        stim_q[0].push_back(8'hA5);
        drain();
        check("single_count", log_q.size(), 1);
        if (log_q.size() == 1) check("single_byte", log_q[0], 8'hA5);
        check("single_grant", bus.grant_id, 0);

        // random traffic with random baud strobes and frame lengths
        rand_busy = 1'b1;
        base = txwr_count;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 25)) @(negedge clk);
            @(negedge clk);
            k = int'($urandom_range(0, 1));
            r = $urandom;
            stim_q[k].push_back(r[7:0]);
            if ($urandom_range(0, 3) == 0) pulse_cfg(3'($urandom_range(0, 7)));
        end
        drain();
        rand_busy = 1'b0;
        check("random_frames", txwr_count - base, 40);

        // baud change requested mid-frame waits for the frame to end
        pulse_cfg(3'd0);
        drain();
        check("baud_preset", bus.baud_select, 0);
        base = cfg_count;
        log_q.delete();
        @(negedge clk);
        stim_q[0].push_back(8'h71); stim_q[0].push_back(8'h72);
        wait_model_busy();
        pulse_cfg(3'd5);
        check("baud_held_in_frame", bus.baud_select, 0);
        drain();
        check("baud_applied", bus.baud_select, 5);
        check("cfg_once", cfg_count - base, 1);
        check("frame_after_cfg", (last_txwr_time > last_cfg_time), 1);
        check("cfg_frames", log_q.size(), 2);

        // Tx_BUSY never rises: timeout after RISE_TIMEOUT cycles in WAIT_BUSY
        stuck = 1'b1;
        @(negedge clk);
        stim_q[0].push_back(8'h9C);
        wait_txwr();
        check("timeout_err_pre", bus.timeout_err, 0);
        n = 0;
        while (!bus.timeout_err && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", n, RISE_TIMEOUT + 1);
        stuck = 1'b0;
        log_q.delete();
        @(negedge clk);
        stim_q[1].push_back(8'h3E);
        drain();
        check("after_timeout_count", log_q.size(), 1);
        if (log_q.size() == 1) check("after_timeout_byte", log_q[0], 8'h3E);
        check("timeout_sticky", bus.timeout_err, 1);

        // external Tx_BUSY while idle holds off a pending request
        @(posedge clk); #1 busy_force = 1'b1;
        log_q.delete();
        base = txwr_count;
        @(negedge clk);
        stim_q[0].push_back(8'h5A);
        repeat (12) @(negedge clk);
        check("busy_blocks_wr", txwr_count - base, 0);
        check("busy_req_waiting", exp_q[0].size(), 1);
        @(posedge clk); #1 busy_force = 1'b0;
        drain();
        check("busy_release_count", log_q.size(), 1);
        if (log_q.size() == 1) check("busy_release_byte", log_q[0], 8'h5A);

        // reset asserted between edges during WAIT_DONE
        @(negedge clk);
        stim_q[0].push_back(8'h6D);
        wait_model_busy();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        #1 reset = 1'b1;
        log_q.delete();
        @(negedge clk);
        stim_q[0].push_back(8'h01);
        stim_q[1].push_back(8'h02);
        drain();
        check("post_rst_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("post_rst_first",  log_q[0], 8'h01);
            check("post_rst_second", log_q[1], 8'h02);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    // Global bound on run time.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
